imem_region_router: RTL and testbench

//  Instruction-fetch router between the CPU fetch port and NUM_REGIONS instruction memories (ROM, RAM, ...).

---
 rtl/imem_region_router.sv | 68 ++++++
 tb/tb_imem_region_router.sv | 134 +++++++++++++
 2 files changed

// File: rtl/imem_region_router.sv
// imem_region_router: routes fetches to base/size-decoded instruction memories with fault and flush handling
module imem_region_router #(
  parameter int NUM_REGIONS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LATENCY = 1,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {32'h2800, 32'h2000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = {32'h0800, 32'h0800}
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic                          flush,
  output logic                          resp_valid,
  output logic [DATA_W-1:0]             resp_instr,
  output logic                          resp_fault,
  output logic [15:0]                   fault_count,
  output logic [NUM_REGIONS-1:0]        mem_rd,
  output logic [NUM_REGIONS*ADDR_W-1:0] mem_addr_o,
  input  logic [NUM_REGIONS*DATA_W-1:0] mem_data_i
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int SW = NUM_REGIONS > 1 ? $clog2(NUM_REGIONS) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sel, hit_sel;
  logic [NUM_REGIONS-1:0] hits;
  logic hit, aligned, accept, resp_cycle;
  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_dec
    assign mem_addr_o[i*ADDR_W +: ADDR_W] = req_addr - REGION_BASE[i*ADDR_W +: ADDR_W];
    assign hits[i] = req_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                     mem_addr_o[i*ADDR_W +: ADDR_W] < REGION_SIZE[i*ADDR_W +: ADDR_W];
  end
  // Descending scan so the lowest-index hit wins on overlapping windows
  always_comb begin
    hit_sel = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) if (hits[i]) hit_sel = SW'(i);
  end
  assign hit = |hits;
  assign aligned = req_addr[1:0] == 2'b00;
  assign resp_cycle = (state == BUSY && cnt == CW'(1)) || state == FAULT;
  assign req_ready = !flush && (state == IDLE || resp_cycle);
  assign accept = req_valid && req_ready;
  assign resp_valid = !flush && resp_cycle;
  assign resp_fault = resp_valid && state == FAULT;
  assign resp_instr = resp_valid && state == BUSY ? mem_data_i[int'(sel)*DATA_W +: DATA_W] : '0;
  assign mem_rd = accept && hit && aligned ? NUM_REGIONS'(1) << hit_sel : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sel <= '0;
      fault_count <= '0;
    end else begin
      if (state == FAULT && !flush && fault_count != 16'hFFFF) fault_count <= fault_count + 16'd1;
      if (flush) state <= IDLE;
      else if (accept) begin
        state <= hit && aligned ? BUSY : FAULT;
        sel <= hit_sel;
        cnt <= CW'(MEM_LATENCY);
      end else if (resp_cycle) state <= IDLE;
      else if (state == BUSY) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_imem_region_router.sv
// tb_imem_region_router: random and directed fetches on latency-1 and latency-3 routers vs a pending-fetch model
module tb_imem_region_router;
  localparam logic [31:0] BASE [2] = '{32'h2000, 32'h2800};
  localparam logic [31:0] SIZE [2] = '{32'h0800, 32'h0800};
  localparam int LAT [2] = '{1, 3};
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, req_valid = 0, flush = 0, run = 0;
  logic [31:0] req_addr = 0;
  logic [63:0] mem_data = 0;
  logic ready [2], rv [2], rf [2];
  logic [31:0] instr [2];
  logic [15:0] fc [2];
  logic [1:0] rd [2];
  logic [63:0] maddr [2];
  int errors = 0, checks = 0, cyc = 0;
  bit pend [2], pf [2];
  int due [2], preg [2];
  logic [15:0] fcnt [2];
  imem_region_router u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[0]), .req_addr(req_addr),
    .flush(flush), .resp_valid(rv[0]), .resp_instr(instr[0]), .resp_fault(rf[0]),
    .fault_count(fc[0]), .mem_rd(rd[0]), .mem_addr_o(maddr[0]), .mem_data_i(mem_data));
  imem_region_router #(.MEM_LATENCY(3)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[1]), .req_addr(req_addr),
    .flush(flush), .resp_valid(rv[1]), .resp_instr(instr[1]), .resp_fault(rf[1]),
    .fault_count(fc[1]), .mem_rd(rd[1]), .mem_addr_o(maddr[1]), .mem_data_i(mem_data));
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  // A fetch is a pending entry due at a known cycle; faults are due one cycle after acceptance
  always @(negedge clk) if (run) begin
    for (int k = 0; k < 2; k++) begin
      int r;
      bit ok, rc, erdy, acc, erv;
      string p;
      r = -1;
      for (int i = 1; i >= 0; i--) if (req_addr >= BASE[i] && req_addr - BASE[i] < SIZE[i]) r = i;
      ok = r >= 0 && req_addr[1:0] == 2'b00;
      rc = pend[k] && cyc == due[k];
      erdy = !flush && (!pend[k] || rc);
      acc = req_valid && erdy;
      erv = rc && !flush;
      p = $sformatf("lat%0d.", LAT[k]);
      if (!rst) begin
        check({p, "req_ready"}, 64'(ready[k]), 64'(erdy));
        check({p, "resp_valid"}, 64'(rv[k]), 64'(erv));
        check({p, "resp_fault"}, 64'(rf[k]), 64'(erv && pf[k]));
        check({p, "resp_instr"}, 64'(instr[k]), erv && !pf[k] ? 64'(mem_data[preg[k]*32 +: 32]) : 64'd0);
        check({p, "mem_rd"}, 64'(rd[k]), acc && ok ? 64'(1) << r : 64'd0);
        check({p, "fault_count"}, 64'(fc[k]), 64'(fcnt[k]));
        check({p, "mem_addr"}, maddr[k], {req_addr - BASE[1], req_addr - BASE[0]});
      end
      if (rst) begin
        pend[k] = 0;
        fcnt[k] = 0;
      end else if (flush) pend[k] = 0;
      else begin
        if (rc) begin
          pend[k] = 0;
          if (pf[k] && fcnt[k] != 16'hFFFF) fcnt[k] = fcnt[k] + 1;
        end
        if (acc) begin
          pend[k] = 1;
          pf[k] = !ok;
          preg[k] = r;
          due[k] = cyc + (ok ? LAT[k] : 1);
        end
      end
    end
    cyc++;
  end
  task automatic drive(bit v, logic [31:0] a, bit f, bit r);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr = a;
    flush = f;
    rst = r;
    mem_data = {$urandom, $urandom};
  endtask
  initial begin
    logic [31:0] pool [10];
    pool = '{32'h2000, 32'h2004, 32'h27FC, 32'h2800, 32'h2FFC, 32'h3000, 32'h1FFC, 32'h2002, 32'h2801, 32'h0};
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; pf[k] = 0; due[k] = 0; preg[k] = 0; fcnt[k] = 0;
    end
    run = 1;
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(1, 32'h2804, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(1, 32'h2000, 0, 0);
    drive(1, 32'h2004, 0, 0);
    drive(1, 32'h2800, 0, 0);
    repeat (8) drive(0, 0, 0, 0);
    drive(1, 32'h3000, 0, 0);
    drive(0, 0, 0, 0);
    drive(1, 32'h2002, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(1, 32'h2010, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(1, 32'h2010, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(1, 32'h2814, 0, 0);
    repeat (4) drive(0, 0, 0, 0);
    drive(1, 32'h2018, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      int s;
      logic [31:0] a;
      s = int'($urandom_range(0, 9));
      a = s == 9 ? $urandom : pool[s];
      drive($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0);
    end
    drive(0, 0, 0, 0);
    for (int n = 0; n < 65540; n++) drive(1, 32'h3000, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    drive(1, 32'h2FFE, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    @(negedge clk);
    #1;
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
